// File: rtl/pong_pkg.sv
// Shared Pong constants: playfield bounds, HID keycodes, paddle speed ramp and paddle FSM states.
package pong_pkg;
  localparam int Y_MIN        = 20;
  localparam int Y_MAX        = 461;
  localparam int Y_CENTER     = 240;
  localparam int SPEED_MIN    = 2;
  localparam int SPEED_MAX    = 8;
  localparam int ACCEL_FRAMES = 4;

  localparam logic [7:0] KEY_W  = 8'h1A;
  localparam logic [7:0] KEY_S  = 8'h16;
  localparam logic [7:0] KEY_UP = 8'h52;
  localparam logic [7:0] KEY_DN = 8'h51;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN} pad_state_e;

  function automatic logic key_hit(input logic [7:0] k0, input logic [7:0] k1,
                                   input logic [7:0] code);
    return (k0 == code) || (k1 == code);
  endfunction
endpackage

// File: rtl/paddle_axis.sv
// One paddle's vertical motion: direction FSM, held-key speed ramp and playfield clamp.
module paddle_axis
  import pong_pkg::*;
#(
  parameter int PAD_L = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       clr,
  input  logic       up,
  input  logic       dn,
  input  logic       fixed_spd,
  output logic [9:0] y
);
  localparam logic signed [10:0] Y_LO = 11'(Y_MIN + PAD_L);
  localparam logic signed [10:0] Y_HI = 11'(Y_MAX - PAD_L);

  pad_state_e state, state_n;
  logic [3:0] spd, spd_n, eff;
  logic [3:0] cnt, cnt_n, cnt_cur;
  logic [9:0] y_n;
  logic signed [10:0] y_mv;

  always_comb begin
    state_n = IDLE;
    spd_n   = '0;
    cnt_n   = '0;
    eff     = '0;
    cnt_cur = '0;
    y_mv    = $signed({1'b0, y});
    y_n     = y;
    if (clr) begin
      y_n = 10'(Y_CENTER);
    end else if (up ^ dn) begin
      state_n = up ? MOVE_UP : MOVE_DN;
      // Entering from IDLE or reversing restarts the ramp at the minimum speed.
      if (state_n != state) begin
        eff     = 4'(SPEED_MIN);
        cnt_cur = '0;
      end else begin
        eff     = spd;
        cnt_cur = cnt;
      end
      if (fixed_spd) eff = 4'(SPEED_MIN + 1);
      if (cnt_cur == 4'(ACCEL_FRAMES - 1)) begin
        cnt_n = '0;
        spd_n = (eff >= 4'(SPEED_MAX)) ? 4'(SPEED_MAX) : eff + 4'd1;
      end else begin
        cnt_n = cnt_cur + 4'd1;
        spd_n = eff;
      end
      y_mv = up ? $signed({1'b0, y}) - $signed({7'b0, eff})
                : $signed({1'b0, y}) + $signed({7'b0, eff});
      if (y_mv < Y_LO)      y_n = 10'(Y_LO);
      else if (y_mv > Y_HI) y_n = 10'(Y_HI);
      else                  y_n = y_mv[9:0];
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      spd   <= '0;
      cnt   <= '0;
      y     <= 10'(Y_CENTER);
    end else begin
      state <= state_n;
      spd   <= spd_n;
      cnt   <= cnt_n;
      y     <= y_n;
    end
  end
endmodule

// File: rtl/paddle_ctrl.sv
// Keyboard-driven Pong paddles; optional paddle-2 ball tracking when PADDLE_AI_EN is defined.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int P1_X  = 50,
  parameter int P2_X  = 580,
  parameter int PAD_L = 30,
  parameter int PAD_W = 4
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic       resetB,
  input  logic [9:0] BallY,
  input  logic       ai_mode,
  output logic [9:0] Paddle1X,
  output logic [9:0] Paddle1Y,
  output logic [9:0] Paddle1L,
  output logic [9:0] Paddle1W,
  output logic [9:0] Paddle2X,
  output logic [9:0] Paddle2Y,
  output logic [9:0] Paddle2L,
  output logic [9:0] Paddle2W
);
  logic [1:0]       up_v, dn_v, fix_v;
  logic [1:0][9:0]  y_v;
  logic             k2_up, k2_dn;

  assign k2_up = key_hit(keycode0, keycode1, KEY_UP);
  assign k2_dn = key_hit(keycode0, keycode1, KEY_DN);

  assign up_v[0]  = key_hit(keycode0, keycode1, KEY_W);
  assign dn_v[0]  = key_hit(keycode0, keycode1, KEY_S);
  assign fix_v[0] = 1'b0;

`ifdef PADDLE_AI_EN
  logic [10:0] ball_w, p2_w;
  logic        ai_up, ai_dn;
  assign ball_w = {1'b0, BallY};
  assign p2_w   = {1'b0, y_v[1]};
  // 4-pixel dead band keeps the AI paddle from dithering around the ball.
  assign ai_dn  = ball_w > p2_w + 11'd4;
  assign ai_up  = ball_w + 11'd4 < p2_w;
  assign up_v[1]  = ai_mode ? ai_up : k2_up;
  assign dn_v[1]  = ai_mode ? ai_dn : k2_dn;
  assign fix_v[1] = ai_mode;
`else
  logic unused_ai;
  assign unused_ai = ^{ai_mode, BallY};
  assign up_v[1]  = k2_up;
  assign dn_v[1]  = k2_dn;
  assign fix_v[1] = 1'b0;
`endif

  for (genvar i = 0; i < 2; i++) begin : g_pad
    paddle_axis #(.PAD_L(PAD_L)) u_axis (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .clr       (resetB),
      .up        (up_v[i]),
      .dn        (dn_v[i]),
      .fixed_spd (fix_v[i]),
      .y         (y_v[i])
    );
  end

  assign Paddle1Y = y_v[0];
  assign Paddle2Y = y_v[1];
  assign Paddle1X = 10'(P1_X);
  assign Paddle2X = 10'(P2_X);
  assign Paddle1L = 10'(PAD_L);
  assign Paddle2L = 10'(PAD_L);
  assign Paddle1W = 10'(PAD_W);
  assign Paddle2W = 10'(PAD_W);
endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: ramp, dual-key, clamp, serve reset, async reset, AI/keyboard select.
module tb_paddle_ctrl;
  logic       Reset, frame_clk, resetB, ai_mode;
  logic [7:0] keycode0, keycode1;
  logic [9:0] BallY;
  logic [9:0] Paddle1X, Paddle1Y, Paddle1L, Paddle1W;
  logic [9:0] Paddle2X, Paddle2Y, Paddle2L, Paddle2W;

  int n_chk = 0;
  int n_fail = 0;

  paddle_ctrl dut (
    .Reset(Reset), .frame_clk(frame_clk), .keycode0(keycode0), .keycode1(keycode1),
    .resetB(resetB), .BallY(BallY), .ai_mode(ai_mode),
    .Paddle1X(Paddle1X), .Paddle1Y(Paddle1Y), .Paddle1L(Paddle1L), .Paddle1W(Paddle1W),
    .Paddle2X(Paddle2X), .Paddle2Y(Paddle2Y), .Paddle2L(Paddle2L), .Paddle2W(Paddle2W)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  int ramp_exp [9] = '{242, 244, 246, 248, 251, 254, 257, 260, 264};
  int min_y;

  initial begin
    Reset = 1'b1; resetB = 1'b0; ai_mode = 1'b0;
    keycode0 = 8'h00; keycode1 = 8'h00; BallY = 10'd0;
    #12;
    check("rst_p1y", Paddle1Y, 240);
    check("rst_p2y", Paddle2Y, 240);
    check("p1x", Paddle1X, 50);
    check("p2x", Paddle2X, 580);
    check("p1l", Paddle1L, 30);
    check("p2w", Paddle2W, 4);
    #1 Reset = 1'b0;

    // S held: ramp 2,2,2,2,3,3,3,3,4
    keycode0 = 8'h16;
    check("ramp_y0", Paddle1Y, 240);
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("ramp_y%0d", i + 1), Paddle1Y, ramp_exp[i]);
    end
    check("ramp_p2", Paddle2Y, 240);
    keycode0 = 8'h00;
    step();
    check("release_hold", Paddle1Y, 264);

    // W and S together: no motion
    keycode0 = 8'h1A; keycode1 = 8'h16;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("both_keys%0d", i), Paddle1Y, 264);
    end
    keycode1 = 8'h00;
    step();
    check("w_first_step", Paddle1Y, 262);

    // reverse P1 to down and drive P2 up simultaneously for 13 frames
    keycode0 = 8'h16; keycode1 = 8'h52;
    repeat (13) step();
    check("rev_p1", Paddle1Y, 303);
    check("p2_up13", Paddle2Y, 199);
    resetB = 1'b1;
    step();
    check("serve_p1", Paddle1Y, 240);
    check("serve_p2", Paddle2Y, 240);
    resetB = 1'b0;
    step();
    check("post_serve_p1", Paddle1Y, 242);
    check("post_serve_p2", Paddle2Y, 238);
    keycode0 = 8'h00; keycode1 = 8'h00;
    step();

    // P2 up for 100 frames: clamps at 50
    keycode0 = 8'h52;
    min_y = 1023;
    repeat (100) begin
      step();
      if (int'(Paddle2Y) < min_y) min_y = int'(Paddle2Y);
    end
    check("p2_min", min_y, 50);
    check("p2_top", Paddle2Y, 50);
    check("p1_still", Paddle1Y, 242);
    keycode0 = 8'h00;
    step();

    // P1 down long: speed caps at 8, then bottom clamp 431
    keycode0 = 8'h16;
    for (int f = 1; f <= 36; f++) begin
      step();
      if (f == 24) check("cap_f24", Paddle1Y, 350);
      if (f == 29) check("cap_f29", Paddle1Y, 390);
      if (f == 35) check("bot_f35", Paddle1Y, 431);
      if (f == 36) check("bot_f36", Paddle1Y, 431);
    end

    // async Reset between edges
    keycode0 = 8'h00; resetB = 1'b1;
    step();
    resetB = 1'b0; keycode1 = 8'h51;
    repeat (31) step();
    check("p2_down31", Paddle2Y, 404);
    #3 Reset = 1'b1;
    #1;
    check("async_p2", Paddle2Y, 240);
    check("async_p1", Paddle1Y, 240);
    keycode1 = 8'h00;
    #2 Reset = 1'b0;
    step();
    check("after_async", Paddle2Y, 240);

    // ai_mode with P2 up key held
    ai_mode = 1'b1; BallY = 10'd400; keycode0 = 8'h52;
    step();
`ifdef PADDLE_AI_EN
    check("ai_step", Paddle2Y, 243);
    repeat (60) step();
    check("ai_hold", Paddle2Y, 396);
    step();
    check("ai_hold2", Paddle2Y, 396);
`else
    check("kbd_only", Paddle2Y, 238);
    BallY = 10'd100;
    step();
    check("kbd_only2", Paddle2Y, 236);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
